// File: rtl/freq_counter_slave_if.sv
// Register-bus bundle between the measurement control unit and the frequency counter.
// Latency: none, the bundle is wiring only.
// Backpressure: none; the slave answers combinationally in the same cycle.
interface freq_counter_slave_if;
  logic [31:0] addr;
  logic [31:0] wr_dat;
  logic [31:0] rd_dat;
  logic        we;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (
    output addr, wr_dat, we, sel, cyc, stb,
    input  rd_dat, ack, err
  );

  modport slave (
    input  addr, wr_dat, we, sel, cyc, stb,
    output rd_dat, ack, err
  );
endinterface

// File: rtl/freq_counter_slave.sv
// Frequency counter slave: counts rising edges of sig_i over a GATE_CYCLES window.
// Latency: bus read/ack/err combinational; DONE and result visible GATE_CYCLES+1 edges after START.
// Backpressure: none; every strobed cycle is accepted, a held write strobe repeats the write.
module freq_counter_slave #(
  parameter logic [31:0] GATE_CYCLES = 32'd50_000_000,
  parameter logic [31:0] ADDR_CTRL   = 32'h8,
  parameter logic [31:0] ADDR_RESULT = 32'h9
) (
  input  logic           clk_i,
  input  logic           ext_rst_i,
  input  logic           sig_i,
  freq_counter_slave_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LATCH   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] gate_cnt;
  logic [31:0] edge_cnt;
  logic [31:0] result;
  logic        done;
  logic        sync_1;
  logic        sync_2;
  logic        sync_prev;
  logic        edge_pulse;

  logic        hit_ctrl;
  logic        hit_result;
  logic        wr_ctrl;
  logic        clr_req;
  logic        start_req;
  logic        busy;
  logic [31:0] ctrl_val;

  // Bus fields that carry no meaning for this slave.
  logic unused_bus;
  assign unused_bus = ^{bus.cyc, bus.sel[3:1], bus.wr_dat[31:8], bus.wr_dat[6:1]};

  // Address decode and control-write strobes; CLR takes priority over START.
  always_comb begin
    hit_ctrl   = (bus.addr == ADDR_CTRL);
    hit_result = (bus.addr == ADDR_RESULT);
    wr_ctrl    = bus.stb & bus.we & hit_ctrl & bus.sel[0];
    clr_req    = wr_ctrl & bus.wr_dat[0];
    start_req  = wr_ctrl & bus.wr_dat[7] & ~bus.wr_dat[0];
  end

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= sig_i;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign edge_pulse = sync_2 & ~sync_prev;

  // FSM state register.
  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; bus commands override the gate sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    state_nxt = ST_IDLE;
      ST_MEASURE: if (gate_cnt == 32'd1) state_nxt = ST_LATCH;
      ST_LATCH:   state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (start_req) state_nxt = ST_MEASURE;
    if (clr_req)   state_nxt = ST_IDLE;
  end

  // Gate counter, saturating edge counter, result capture and sticky DONE.
  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      gate_cnt <= 32'd0;
      edge_cnt <= 32'd0;
      result   <= 32'd0;
      done     <= 1'b0;
    end else if (clr_req) begin
      gate_cnt <= 32'd0;
      edge_cnt <= 32'd0;
      result   <= 32'd0;
      done     <= 1'b0;
    end else if (start_req) begin
      gate_cnt <= GATE_CYCLES;
      edge_cnt <= 32'd0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_MEASURE: begin
          gate_cnt <= gate_cnt - 32'd1;
          if (edge_pulse && (edge_cnt != 32'hFFFF_FFFF)) begin
            edge_cnt <= edge_cnt + 32'd1;
          end
        end
        ST_LATCH: begin
          result <= edge_cnt;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign ctrl_val = {24'd0, 1'b0, done, busy, 5'd0};

  // Combinational response; read data is zero unless selected so slaves can be OR-muxed.
  always_comb begin
    bus.rd_dat = 32'd0;
    bus.ack    = ext_rst_i & bus.stb & (hit_ctrl | hit_result);
    bus.err    = ext_rst_i & bus.stb & bus.we & hit_result;
    if (ext_rst_i && bus.stb && !bus.we) begin
      if (hit_ctrl)        bus.rd_dat = ctrl_val;
      else if (hit_result) bus.rd_dat = result;
    end
  end

endmodule

// File: tb/tb_freq_counter_slave.sv
module tb_freq_counter_slave;

  localparam logic [31:0] GATE = 32'd100;

  logic clk_i     = 1'b0;
  logic ext_rst_i = 1'b0;
  logic sig_i     = 1'b0;
  bit   sig_en    = 1'b0;
  int   sig_half_ns = 50;

  int n_pass  = 0;
  int n_total = 0;
  int busy_drop = 0;

  always #5 clk_i = ~clk_i;

  // Measured signal, free-running asynchronously to clk_i when enabled.
  always begin
    if (sig_en) begin
      #(sig_half_ns);
      sig_i = ~sig_i;
    end else begin
      sig_i = 1'b0;
      #7;
    end
  end

  freq_counter_slave_if bus();

  freq_counter_slave #(
    .GATE_CYCLES(GATE),
    .ADDR_CTRL  (32'h8),
    .ADDR_RESULT(32'h9)
  ) dut (
    .clk_i    (clk_i),
    .ext_rst_i(ext_rst_i),
    .sig_i    (sig_i),
    .bus      (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] exp_dat;
    logic        exp_ack;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic check_range(input string name, input logic [31:0] act,
                             input logic [31:0] lo, input logic [31:0] hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
  endtask

  task automatic bus_idle();
    bus.addr   = 32'd0;
    bus.wr_dat = 32'd0;
    bus.we     = 1'b0;
    bus.sel    = 4'h0;
    bus.cyc    = 1'b0;
    bus.stb    = 1'b0;
  endtask

  // Combinational read; caller keeps it clear of the rising edge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.we   = 1'b0;
    bus.sel  = 4'h0;
    bus.cyc  = 1'b1;
    bus.stb  = 1'b1;
    #1;
    d = bus.rd_dat;
    bus_idle();
  endtask

  // Single-cycle write; returns 1 ns after the edge that sampled it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk_i);
    bus.addr   = a;
    bus.wr_dat = d;
    bus.we     = 1'b1;
    bus.sel    = s;
    bus.cyc    = 1'b1;
    bus.stb    = 1'b1;
    @(posedge clk_i);
    #1;
    bus_idle();
  endtask

  // Polls CTRL after every edge; k is the edge index at which DONE first reads 1, -1 on timeout.
  task automatic wait_done(output int k);
    k = -1;
    busy_drop = 0;
    bus.addr = 32'h8;
    bus.we   = 1'b0;
    bus.stb  = 1'b1;
    bus.cyc  = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk_i);
      #1;
      if (bus.rd_dat[6]) begin
        k = i;
        break;
      end
      if (!bus.rd_dat[5]) busy_drop++;
    end
    bus_idle();
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] saved;
    int          k;

    bus_idle();

    vecs[0] = '{32'h8, 1'b0, 4'hF, 32'h0,    32'h0, 1'b1, 1'b0};
    vecs[1] = '{32'h9, 1'b0, 4'hF, 32'h0,    32'h0, 1'b1, 1'b0};
    vecs[2] = '{32'h5, 1'b0, 4'hF, 32'h0,    32'h0, 1'b0, 1'b0};
    vecs[3] = '{32'h9, 1'b1, 4'hF, 32'h1234, 32'h0, 1'b1, 1'b1};
    vecs[4] = '{32'h9, 1'b0, 4'h0, 32'h0,    32'h0, 1'b1, 1'b0};
    vecs[5] = '{32'h8, 1'b1, 4'h2, 32'h80,   32'h0, 1'b1, 1'b0};
    vecs[6] = '{32'h8, 1'b0, 4'h0, 32'h0,    32'h0, 1'b1, 1'b0};
    vecs[7] = '{32'h8, 1'b1, 4'hF, 32'h7E,   32'h0, 1'b1, 1'b0};
    vecs[8] = '{32'h8, 1'b0, 4'hF, 32'h0,    32'h0, 1'b1, 1'b0};
    vecs[9] = '{32'h5, 1'b1, 4'hF, 32'hFF,   32'h0, 1'b0, 1'b0};

    // Reset: outputs quiet with no strobe.
    #23;
    check("rst_dat", bus.rd_dat, 32'h0);
    check("rst_ack", {31'd0, bus.ack}, 32'h0);
    check("rst_err", {31'd0, bus.err}, 32'h0);
    @(negedge clk_i);
    ext_rst_i = 1'b1;
    #1;
    check("post_rst_nostb_ack", {31'd0, bus.ack}, 32'h0);
    check("post_rst_nostb_dat", bus.rd_dat, 32'h0);

    // Table of single-cycle bus accesses from the idle, cleared state.
    foreach (vecs[i]) begin
      @(negedge clk_i);
      bus.addr   = vecs[i].addr;
      bus.we     = vecs[i].we;
      bus.sel    = vecs[i].sel;
      bus.wr_dat = vecs[i].wdat;
      bus.cyc    = 1'b1;
      bus.stb    = 1'b1;
      #1;
      check($sformatf("vec%0d_dat", i), bus.rd_dat, vecs[i].exp_dat);
      check($sformatf("vec%0d_ack", i), {31'd0, bus.ack}, {31'd0, vecs[i].exp_ack});
      check($sformatf("vec%0d_err", i), {31'd0, bus.err}, {31'd0, vecs[i].exp_err});
      @(posedge clk_i);
      #1;
      bus_idle();
    end

    // Nominal measurement: 10-clock signal period over a 100-cycle gate.
    sig_half_ns = 50;
    sig_en = 1'b1;
    #200;
    bus_write(32'h8, 32'h80, 4'h1);
    wait_done(k);
    check("nom_done_cycle", 32'(k), 32'd101);
    check("nom_busy_drop", 32'(busy_drop), 32'd0);
    bus_read(32'h9, rd);
    check_range("nom_result", rd, 32'd9, 32'd11);
    saved = rd;
    bus_read(32'h8, rd);
    check("nom_ctrl_done", rd, 32'h40);

    // Write to RESULT is rejected and leaves it intact.
    bus_write(32'h9, 32'hDEAD_BEEF, 4'hF);
    bus_read(32'h9, rd);
    check("res_write_ignored", rd, saved);

    // Restart: second START 40 cycles in pushes DONE out.
    bus_write(32'h8, 32'h80, 4'h1);
    repeat (39) @(posedge clk_i);
    #1;
    bus_read(32'h8, rd);
    check("restart_mid_ctrl", rd, 32'h20);
    bus_write(32'h8, 32'h80, 4'h1);
    wait_done(k);
    check("restart_done_cycle", 32'(k), 32'd101);

    // CLR together with START: CLR wins.
    bus_write(32'h8, 32'h81, 4'h1);
    bus_read(32'h8, rd);
    check("clr_ctrl", rd, 32'h0);
    bus_read(32'h9, rd);
    check("clr_result", rd, 32'h0);

    // CLR during MEASURE aborts; no DONE afterwards.
    bus_write(32'h8, 32'h80, 4'h1);
    repeat (20) @(posedge clk_i);
    bus_write(32'h8, 32'h01, 4'h1);
    bus_read(32'h8, rd);
    check("abort_ctrl", rd, 32'h0);
    repeat (150) @(posedge clk_i);
    #1;
    bus_read(32'h8, rd);
    check("abort_no_done", rd, 32'h0);

    // Saturation: preload the count near the top, fast signal must not wrap it.
    sig_half_ns = 20;
    bus_write(32'h8, 32'h80, 4'h1);
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    force dut.edge_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.edge_cnt;
    wait_done(k);
    check("sat_done_seen", {31'd0, k > 0}, 32'd1);
    bus_read(32'h9, rd);
    check("sat_result", rd, 32'hFFFF_FFFF);

    // Async reset pulse mid-MEASURE between clock edges.
    sig_half_ns = 50;
    bus_write(32'h8, 32'h80, 4'h1);
    repeat (30) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    ext_rst_i = 1'b0;
    #1;
    check("arst_gate_cnt", dut.gate_cnt, 32'h0);
    #1;
    ext_rst_i = 1'b1;
    bus_read(32'h8, rd);
    check("arst_ctrl", rd, 32'h0);
    #1;
    bus_read(32'h9, rd);
    check("arst_result", rd, 32'h0);
    bus_write(32'h8, 32'h80, 4'h1);
    wait_done(k);
    check("arst_new_done_cycle", 32'(k), 32'd101);
    bus_read(32'h9, rd);
    check_range("arst_new_result", rd, 32'd9, 32'd11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
